// File: rtl/bypass_rx_route_decoder.sv
// Route decoder at the vIO Switch egress of a vFIU.
// Checks each packet's route_id (tdest) against this vFPGA and steers it
// to the bypass RX sink or the general sink, or drops it whole.
// Ports:
//   aclk/aresetn      clock, synchronous active-low reset
//   s_axis_*          input stream from the switch (tdest = route_id)
//   m_byp_*           bypass RX sink
//   m_oth_*           general sink (tid = sender_id, tuser = flags)
//   drop_cnt/pulse    saturating dropped-packet count, per-drop pulse

module bypass_rx_route_decoder_skid #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         pop;

  assign pop   = valid && ready;
  assign valid = (cnt != 2'd0);
  assign full  = (cnt == 2'd2);
  assign dout  = mem[rp];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

module bypass_rx_route_decoder #(
  parameter int         DATA_BITS      = 512,
  parameter int         N_REGIONS      = 4,
  parameter logic [3:0] VFID           = 4'd0,
  parameter logic [3:0] PORT_BYPASS_RX = 4'(N_REGIONS + 6),
  parameter int         CNT_BITS       = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [13:0]            s_axis_tdest,
  output logic                   m_byp_tvalid,
  input  logic                   m_byp_tready,
  output logic [DATA_BITS-1:0]   m_byp_tdata,
  output logic [DATA_BITS/8-1:0] m_byp_tkeep,
  output logic                   m_byp_tlast,
  output logic                   m_oth_tvalid,
  input  logic                   m_oth_tready,
  output logic [DATA_BITS-1:0]   m_oth_tdata,
  output logic [DATA_BITS/8-1:0] m_oth_tkeep,
  output logic                   m_oth_tlast,
  output logic [3:0]             m_oth_tid,
  output logic [1:0]             m_oth_tuser,
  output logic [CNT_BITS-1:0]    drop_cnt,
  output logic                   drop_pulse
);
  localparam int KW = DATA_BITS / 8;
  localparam int BW = DATA_BITS + KW + 1;
  localparam int OW = BW + 6;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PASS_BYP = 2'd1;
  localparam logic [1:0] S_PASS_OTH = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] dec;
  logic [1:0] tgt;
  logic [3:0] pkt_tid;
  logic [1:0] pkt_tuser;
  logic [3:0] cur_tid;
  logic [1:0] cur_tuser;
  logic       byp_full;
  logic       oth_full;
  logic       rdy;
  logic       accept;
  logic       push_byp;
  logic       push_oth;
  logic       drop_last;
  logic [BW-1:0] byp_dout;
  logic [OW-1:0] oth_dout;

  // decode of the beat currently on the input
  always_comb begin
    dec = S_PASS_OTH;
    if (s_axis_tdest[13:10] != 4'd0 ||
        s_axis_tdest[5:2] != VFID)
      dec = S_DROP;
    else if (s_axis_tdest[9:6] == PORT_BYPASS_RX)
      dec = S_PASS_BYP;
  end

  // in IDLE both buffers must have room since the target is not yet known
  always_comb begin
    rdy = 1'b0;
    tgt = state;
    unique case (1'b1)
      (state == S_IDLE): begin
        rdy = !byp_full && !oth_full;
        tgt = dec;
      end
      (state == S_PASS_BYP): rdy = !byp_full;
      (state == S_PASS_OTH): rdy = !oth_full;
      (state == S_DROP):     rdy = 1'b1;
    endcase
  end

  assign s_axis_tready = aresetn && rdy;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign push_byp  = accept && (tgt == S_PASS_BYP);
  assign push_oth  = accept && (tgt == S_PASS_OTH);
  assign drop_last = accept && (tgt == S_DROP) && s_axis_tlast;

  assign cur_tid   = (state == S_IDLE) ? s_axis_tdest[9:6] : pkt_tid;
  assign cur_tuser = (state == S_IDLE) ? s_axis_tdest[1:0] : pkt_tuser;

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = s_axis_tlast ? S_IDLE : tgt;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      pkt_tid    <= 4'd0;
      pkt_tuser  <= 2'd0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= drop_last;
      if (accept && state == S_IDLE) begin
        pkt_tid   <= s_axis_tdest[9:6];
        pkt_tuser <= s_axis_tdest[1:0];
      end
      if (drop_last && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_BITS'(1);
    end
  end

  bypass_rx_route_decoder_skid #(.W(BW)) u_byp (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push_byp),
    .din     ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .full    (byp_full),
    .valid   (m_byp_tvalid),
    .ready   (m_byp_tready),
    .dout    (byp_dout)
  );

  bypass_rx_route_decoder_skid #(.W(OW)) u_oth (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push_oth),
    .din     ({cur_tuser, cur_tid, s_axis_tlast,
               s_axis_tkeep, s_axis_tdata}),
    .full    (oth_full),
    .valid   (m_oth_tvalid),
    .ready   (m_oth_tready),
    .dout    (oth_dout)
  );

  assign {m_byp_tlast, m_byp_tkeep, m_byp_tdata} = byp_dout;
  assign {m_oth_tuser, m_oth_tid, m_oth_tlast,
          m_oth_tkeep, m_oth_tdata} = oth_dout;
endmodule

// File: tb/tb_bypass_rx_route_decoder.sv
// Bench for bypass_rx_route_decoder (VFID=2, bypass port 10).
// Scoreboard queues per sink, filled on input accept, drained by monitor.

module tb_bypass_rx_route_decoder;
  localparam int DW = 32;
  localparam int KW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic [13:0]   s_axis_tdest = '0;
  logic          m_byp_tvalid;
  logic          m_byp_tready = 1'b1;
  logic [DW-1:0] m_byp_tdata;
  logic [KW-1:0] m_byp_tkeep;
  logic          m_byp_tlast;
  logic          m_oth_tvalid;
  logic          m_oth_tready = 1'b1;
  logic [DW-1:0] m_oth_tdata;
  logic [KW-1:0] m_oth_tkeep;
  logic          m_oth_tlast;
  logic [3:0]    m_oth_tid;
  logic [1:0]    m_oth_tuser;
  logic [31:0]   drop_cnt;
  logic          drop_pulse;

  bypass_rx_route_decoder #(
    .DATA_BITS      (DW),
    .N_REGIONS      (4),
    .VFID           (4'd2),
    .PORT_BYPASS_RX (4'd10),
    .CNT_BITS       (32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdest  (s_axis_tdest),
    .m_byp_tvalid  (m_byp_tvalid),
    .m_byp_tready  (m_byp_tready),
    .m_byp_tdata   (m_byp_tdata),
    .m_byp_tkeep   (m_byp_tkeep),
    .m_byp_tlast   (m_byp_tlast),
    .m_oth_tvalid  (m_oth_tvalid),
    .m_oth_tready  (m_oth_tready),
    .m_oth_tdata   (m_oth_tdata),
    .m_oth_tkeep   (m_oth_tkeep),
    .m_oth_tlast   (m_oth_tlast),
    .m_oth_tid     (m_oth_tid),
    .m_oth_tuser   (m_oth_tuser),
    .drop_cnt      (drop_cnt),
    .drop_pulse    (drop_pulse)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [3:0]  tid;
    logic [1:0]  tu;
    logic [31:0] c;
  } beat_t;

  beat_t q_byp[$];
  beat_t q_oth[$];
  beat_t eb;
  beat_t eo;

  int    n_chk = 0;
  int    n_pass = 0;
  int    n_acc = 0;
  int    pulses = 0;
  int    seq = 0;
  int    cyc = 0;
  bit    lat_chk = 0;
  bit    bp_done = 0;
  bit    byp_stall = 0;
  logic [DW+KW:0] byp_held;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // 0 = drop, 1 = bypass sink, 2 = general sink
  function automatic int route_of(input logic [13:0] d);
    if (d[13:10] != 4'd0) return 0;
    if (d[5:2] != 4'd2) return 0;
    if (d[9:6] == 4'd10) return 1;
    return 2;
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (aresetn && byp_stall)
      chk("byp_hold", {m_byp_tvalid, m_byp_tlast, m_byp_tkeep,
          m_byp_tdata}, {1'b1, byp_held});
    byp_stall = aresetn && m_byp_tvalid && !m_byp_tready;
    byp_held  = {m_byp_tlast, m_byp_tkeep, m_byp_tdata};
    if (m_byp_tvalid && m_byp_tready) begin
      if (q_byp.size() == 0) chk("byp_unexpected", 1, 0);
      else begin
        eb = q_byp.pop_front();
        chk("byp_beat", {m_byp_tdata, m_byp_tkeep, m_byp_tlast},
            {eb.d, eb.k, eb.l});
        if (lat_chk) chk("byp_latency", 32'(cyc) - eb.c, 1);
      end
    end
    if (m_oth_tvalid && m_oth_tready) begin
      if (q_oth.size() == 0) chk("oth_unexpected", 1, 0);
      else begin
        eo = q_oth.pop_front();
        chk("oth_beat", {m_oth_tdata, m_oth_tkeep, m_oth_tlast,
            m_oth_tid, m_oth_tuser}, {eo.d, eo.k, eo.l, eo.tid, eo.tu});
      end
    end
    if (drop_pulse) pulses++;
  end

  task automatic send_beat(input logic [13:0] dest, input logic last,
                           input int rt, input logic [3:0] tid,
                           input logic [1:0] tu, output int waits);
    beat_t e;
    bit    rdy;
    seq++;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hC0DE0000 | 32'(seq);
    s_axis_tkeep  = 4'(seq) | 4'h1;
    s_axis_tlast  = last;
    s_axis_tdest  = dest;
    waits = 0;
    forever begin
      @(negedge aclk);
      rdy = s_axis_tready;
      @(posedge aclk);
      if (rdy) break;
      waits++;
      if (waits > 200) begin
        chk("in_timeout", 0, 1);
        break;
      end
    end
    n_acc++;
    e.d = s_axis_tdata;
    e.k = s_axis_tkeep;
    e.l = last;
    e.tid = tid;
    e.tu = tu;
    e.c = 32'(cyc);
    if (rt == 1) q_byp.push_back(e);
    else if (rt == 2) q_oth.push_back(e);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [13:0] dest, input int n,
                          input logic [13:0] dest_later, output int waits);
    int rt;
    int w;
    rt = route_of(dest);
    waits = 0;
    for (int i = 0; i < n; i++) begin
      send_beat((i == 0) ? dest : dest_later, i == n - 1, rt,
                dest[9:6], dest[1:0], w);
      waits += w;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q_byp.size() != 0 || q_oth.size() != 0) && n < 100) begin
      @(posedge aclk);
      n++;
    end
    chk(tag, q_byp.size() + q_oth.size(), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  int w1;
  int w2;
  int w3;
  int p0;
  int base;
  int n;

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_byp_valid", m_byp_tvalid, 0);
    chk("rst_oth_valid", m_oth_tvalid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_drop_pulse", drop_pulse, 0);
    chk("rst_tid", m_oth_tid, 0);
    chk("rst_tuser", m_oth_tuser, 0);
    chk("rst_tready", s_axis_tready, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // 4-beat bypass packet, latency check on every beat
    lat_chk = 1;
    send_pkt(14'h288, 4, 14'h288, w1);
    drain("byp4_drain");
    lat_chk = 0;
    chk("byp4_drop_cnt", drop_cnt, 0);

    // general sink, tdest change mid-packet ignored
    send_pkt(14'h0C8, 3, 14'h284, w1);
    drain("oth3_drain");

    // wrong receiver, then reserved bit set
    p0 = pulses;
    send_pkt(14'h284, 5, 14'h284, w1);
    send_pkt(14'h1288, 1, 14'h1288, w2);
    chk("drop_no_stall", w1 + w2, 0);
    repeat (3) @(posedge aclk);
    #1;
    chk("drop_cnt_2", drop_cnt, 2);
    chk("drop_pulses_2", pulses - p0, 2);

    // backpressure on bypass sink
    m_byp_tready = 1'b0;
    base = n_acc;
    bp_done = 0;
    fork
      begin
        send_pkt(14'h288, 8, 14'h288, w3);
        bp_done = 1;
      end
    join_none
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    chk("bp_accepted", n_acc - base, 2);
    chk("bp_tready_low", s_axis_tready, 0);
    @(posedge aclk);
    #1 m_byp_tready = 1'b1;
    n = 0;
    while (!bp_done && n < 200) begin
      @(posedge aclk);
      n++;
    end
    chk("bp_done", bp_done, 1);
    drain("bp_drain");

    // back-to-back single-beat packets
    send_pkt(14'h288, 1, 14'h288, w1);
    send_pkt(14'h0C8, 1, 14'h0C8, w2);
    send_pkt(14'h288, 1, 14'h288, w3);
    chk("b2b_no_bubble", w1 + w2 + w3, 0);
    drain("b2b_drain");

    // reset in the middle of a bypass packet
    m_byp_tready = 1'b0;
    send_beat(14'h288, 1'b0, 1, 4'd10, 2'd0, w1);
    send_beat(14'h288, 1'b0, 1, 4'd10, 2'd0, w1);
    s_axis_tvalid = 1'b1;
    s_axis_tdest  = 14'h0C8;
    s_axis_tlast  = 1'b0;
    aresetn = 1'b0;
    @(posedge aclk);
    q_byp.delete();
    @(negedge aclk);
    chk("mid_rst_byp_valid", m_byp_tvalid, 0);
    chk("mid_rst_oth_valid", m_oth_tvalid, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    chk("mid_rst_tready", s_axis_tready, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    m_byp_tready = 1'b1;
    for (int i = 0; i < 4; i++)
      send_beat(14'h0C8, i == 3, 2, 4'd3, 2'd0, w1);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
